// File: rtl/rf_pkg.sv
// Shared types and helpers for the receptive-field window streamer.
// Width helper, FSM state type and window element bit-offset function.
package rf_pkg;

  typedef enum logic {
    FILL,
    STREAM
  } state_t;

  // Counter width for a range of n values (at least 1 bit).
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of window element (k,i,j).
  function automatic int win_idx(
    input int k,
    input int i,
    input int j,
    input int size,
    input int dw
  );
    return ((k * size + i) * size + j) * dw;
  endfunction

endpackage

// File: rtl/rf_line_buffer.sv
// Circular row store: SIZE slots x W columns of one pixel each.
// Ports: write (we/wslot/wcol/wdata), read column rcol -> SIZE cols of all slots.
module rf_line_buffer
  import rf_pkg::*;
#(
  parameter int PW   = 16,
  parameter int SIZE = 5,
  parameter int W    = 32
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [cw(SIZE)-1:0]    wslot,
  input  logic [cw(W)-1:0]       wcol,
  input  logic [PW-1:0]          wdata,
  input  logic [cw(W)-1:0]       rcol,
  output logic [SIZE*SIZE*PW-1:0] rdata
);

  localparam int CWW = cw(W);

  logic [PW-1:0] mem [SIZE][W];

  always_ff @(posedge clk) begin
    if (we) mem[wslot][wcol] <= wdata;
  end

  // Element (s,j) holds column rcol-SIZE+1+j of slot s.
  for (genvar s = 0; s < SIZE; s++) begin : g_s
    for (genvar j = 0; j < SIZE; j++) begin : g_j
      if (j == SIZE - 1) begin : g_cur
        assign rdata[(s*SIZE+j)*PW +: PW] = mem[s][rcol];
      end else begin : g_old
        logic [CWW-1:0] idx;
        assign idx = rcol - CWW'(SIZE - 1 - j);
        assign rdata[(s*SIZE+j)*PW +: PW] =
          (rcol >= CWW'(SIZE - 1 - j)) ? mem[s][idx] : '0;
      end
    end
  end

endmodule

// File: rtl/rf_window_streamer.sv
// Streams raster pixels through a SIZE-row line buffer, emits SIZExSIZE windows.
// Ports: in_pixel/in_valid/in_ready, out_window/out_valid/out_ready/out_last.
module rf_window_streamer
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int Depth      = 1,
  parameter int Size       = 5,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int STRIDE     = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [Depth*DATA_WIDTH-1:0]        in_pixel,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [Depth*Size*Size*DATA_WIDTH-1:0] out_window,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last
);

  localparam int PW    = Depth * DATA_WIDTH;
  localparam int WIN_W = Depth * Size * Size * DATA_WIDTH;
  localparam int RW    = cw(H);
  localparam int CW    = cw(W);
  localparam int SW    = cw(Size);
  localparam int PHW   = cw(STRIDE);
  localparam int OH    = (H - Size) / STRIDE + 1;
  localparam int OW    = (W - Size) / STRIDE + 1;
  localparam int RLAST = Size - 1 + (OH - 1) * STRIDE;
  localparam int CLAST = Size - 1 + (OW - 1) * STRIDE;

  state_t          state, state_n;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [SW-1:0]   slot;
  logic [PHW-1:0]  rph, cph;
  logic            xfer, row_end, frame_end;
  logic            win, last;
  logic [Size*Size*PW-1:0] rdata;
  logic [WIN_W-1:0] win_d;

  assign in_ready  = !out_valid || out_ready;
  assign xfer      = in_valid && in_ready;
  assign row_end   = col == CW'(W - 1);
  assign frame_end = row_end && row == RW'(H - 1);

  // Extra bit keeps the upper-bound compare from folding to constant true.
  assign win = state == STREAM
            && row >= RW'(Size - 1) && col >= CW'(Size - 1)
            && rph == '0 && cph == '0
            && {1'b0, row} <= (RW+1)'(RLAST)
            && {1'b0, col} <= (CW+1)'(CLAST);
  assign last = row == RW'(RLAST) && col == CW'(CLAST);

  rf_line_buffer #(
    .PW   (PW),
    .SIZE (Size),
    .W    (W)
  ) u_lb (
    .clk   (clk),
    .we    (xfer),
    .wslot (slot),
    .wcol  (col),
    .wdata (in_pixel),
    .rcol  (col),
    .rdata (rdata)
  );

  // Window row i lives in slot (slot+1+i) mod Size; the oldest row is next.
  always_comb begin
    int s;
    win_d = '0;
    s     = 0;
    for (int k = 0; k < Depth; k++) begin
      for (int i = 0; i < Size; i++) begin
        s = int'(slot) + 1 + i;
        if (s >= Size) s = s - Size;
        for (int j = 0; j < Size; j++) begin
          if (i == Size - 1 && j == Size - 1)
            win_d[win_idx(k, i, j, Size, DATA_WIDTH) +: DATA_WIDTH] =
              in_pixel[k*DATA_WIDTH +: DATA_WIDTH];
          else
            win_d[win_idx(k, i, j, Size, DATA_WIDTH) +: DATA_WIDTH] =
              rdata[(s*Size+j)*PW + k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (xfer) begin
      unique case (state)
        FILL:   if (row_end && row == RW'(Size - 2)) state_n = STREAM;
        STREAM: if (frame_end) state_n = FILL;
        default: state_n = FILL;
      endcase
    end
  end

  // Phases track (pos-Size+1) mod STRIDE, starting at 0 on position Size-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      row  <= '0;
      col  <= '0;
      slot <= '0;
      rph  <= '0;
      cph  <= '0;
    end else if (xfer) begin
      if (row_end) begin
        col <= '0;
        cph <= '0;
        if (frame_end) begin
          row  <= '0;
          slot <= '0;
          rph  <= '0;
        end else begin
          row  <= row + 1'b1;
          slot <= (slot == SW'(Size - 1)) ? '0 : slot + 1'b1;
          rph  <= (row < RW'(Size - 1)) ? '0 :
                  (rph == PHW'(STRIDE - 1)) ? '0 : rph + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
        cph <= (col < CW'(Size - 1)) ? '0 :
               (cph == PHW'(STRIDE - 1)) ? '0 : cph + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_window <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else if (xfer && win) begin
      out_window <= win_d;
      out_valid  <= 1'b1;
      out_last   <= last;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_window_streamer.sv
// Directed bench for rf_window_streamer on 6x6 images, Size=3.
// Three instances: stride 1, stride 2, two channels.
module tb_rf_window_streamer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic out_ready = 1'b1;
  logic iv1 = 1'b0, iv2 = 1'b0, iv3 = 1'b0;
  logic [15:0] px1 = '0, px2 = '0;
  logic [31:0] px3 = '0;
  logic ir1, ir2, ir3, ov1, ov2, ov3, ol1, ol2, ol3;
  logic [143:0] ow1, ow2;
  logic [287:0] ow3;

  int nassert = 0;
  int nfail = 0;
  int n1 = 0, n2 = 0, n3 = 0, l1 = 0, l2 = 0, l3 = 0;

  always #5 clk = ~clk;

  rf_window_streamer #(
    .DATA_WIDTH(16), .Depth(1), .Size(3), .H(6), .W(6), .STRIDE(1)
  ) u1 (
    .clk(clk), .reset(reset), .in_pixel(px1), .in_valid(iv1),
    .in_ready(ir1), .out_window(ow1), .out_valid(ov1),
    .out_ready(out_ready), .out_last(ol1)
  );

  rf_window_streamer #(
    .DATA_WIDTH(16), .Depth(1), .Size(3), .H(6), .W(6), .STRIDE(2)
  ) u2 (
    .clk(clk), .reset(reset), .in_pixel(px2), .in_valid(iv2),
    .in_ready(ir2), .out_window(ow2), .out_valid(ov2),
    .out_ready(out_ready), .out_last(ol2)
  );

  rf_window_streamer #(
    .DATA_WIDTH(16), .Depth(2), .Size(3), .H(6), .W(6), .STRIDE(1)
  ) u3 (
    .clk(clk), .reset(reset), .in_pixel(px3), .in_valid(iv3),
    .in_ready(ir3), .out_window(ow3), .out_valid(ov3),
    .out_ready(out_ready), .out_last(ol3)
  );

  always @(posedge clk) begin
    if (reset) begin
      n1 <= 0; n2 <= 0; n3 <= 0;
      l1 <= 0; l2 <= 0; l3 <= 0;
    end else if (out_ready) begin
      if (ov1) n1 <= n1 + 1;
      if (ov2) n2 <= n2 + 1;
      if (ov3) n3 <= n3 + 1;
      if (ov1 && ol1) l1 <= l1 + 1;
      if (ov2 && ol2) l2 <= l2 + 1;
      if (ov3 && ol3) l3 <= l3 + 1;
    end
  end

  task automatic chk(input string tag, input logic [287:0] obs,
                     input logic [287:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Image pixel (r,c) = r*6+c; channel 1 adds 100.
  function automatic logic [287:0] ew(input int r0, input int c0,
                                      input int dep);
    logic [287:0] w;
    w = '0;
    for (int k = 0; k < dep; k++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w[((k*3+i)*3+j)*16 +: 16] = 16'((r0+i)*6 + c0 + j + 100*k);
    return w;
  endfunction

  function automatic logic rdy(input int d);
    return (d == 1) ? ir1 : (d == 2) ? ir2 : ir3;
  endfunction

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int v);
    int g;
    g = 0;
    @(negedge clk);
    while (!rdy(d) && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("ready_timeout", 288'(0), 288'(1));
    case (d)
      1: begin px1 = 16'(v); iv1 = 1'b1; end
      2: begin px2 = 16'(v); iv2 = 1'b1; end
      default: begin px3 = {16'(100 + v), 16'(v)}; iv3 = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    iv2 = 1'b0;
    iv3 = 1'b0;
  endtask

  task automatic check_px(input int d, input int p);
    int s, r, c, oh, r0, c0;
    logic win, last, ov, ol;
    logic [287:0] ow;
    s  = (d == 2) ? 2 : 1;
    r  = (p % 36) / 6;
    c  = p % 6;
    oh = (6 - 3) / s + 1;
    r0 = r - 2;
    c0 = c - 2;
    win = (r0 >= 0) && (c0 >= 0);
    if (win) win = (r0 % s == 0) && (c0 % s == 0) && (r0 / s < oh)
                && (c0 / s < oh);
    last = win && (r0 / s == oh - 1) && (c0 / s == oh - 1);
    case (d)
      1: begin ov = ov1; ol = ol1; ow = 288'(ow1); end
      2: begin ov = ov2; ol = ol2; ow = 288'(ow2); end
      default: begin ov = ov3; ol = ol3; ow = ow3; end
    endcase
    chk($sformatf("valid_d%0d_p%0d", d, p), 288'(ov), 288'(win));
    if (win) begin
      chk($sformatf("win_d%0d_p%0d", d, p), ow,
          ew(r0, c0, (d == 3) ? 2 : 1));
      chk($sformatf("last_d%0d_p%0d", d, p), 288'(ol), 288'(last));
    end
  endtask

  task automatic stream(input int d, input int from, input int upto);
    for (int p = from; p <= upto; p++) begin
      push(d, p % 36);
      check_px(d, p);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 288'(ov1), 288'(0));
    chk("rst_last", 288'(ol1), 288'(0));
    chk("rst_window", 288'(ow1), 288'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 288'(ir1), 288'(1));

    stream(1, 0, 35);
    tick();
    chk("s1_count", 288'(n1), 288'(16));
    chk("s1_lasts", 288'(l1), 288'(1));

    do_reset();
    stream(2, 0, 35);
    tick();
    chk("s2_count", 288'(n2), 288'(4));
    chk("s2_lasts", 288'(l2), 288'(1));

    do_reset();
    stream(3, 0, 35);
    tick();
    chk("s3_count", 288'(n3), 288'(16));
    chk("s3_lasts", 288'(l3), 288'(1));

    do_reset();
    stream(1, 0, 14);
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready_%0d", t), 288'(ir1), 288'(0));
      chk($sformatf("bp_valid_%0d", t), 288'(ov1), 288'(1));
      chk($sformatf("bp_window_%0d", t), 288'(ow1), ew(0, 0, 1));
      chk($sformatf("bp_last_%0d", t), 288'(ol1), 288'(0));
    end
    out_ready = 1'b1;
    stream(1, 15, 35);
    tick();
    chk("bp_count", 288'(n1), 288'(16));
    chk("bp_lasts", 288'(l1), 288'(1));

    do_reset();
    stream(1, 0, 20);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 288'(ov1), 288'(0));
    @(negedge clk);
    reset = 1'b0;
    stream(1, 0, 35);
    tick();
    chk("midrst_count", 288'(n1), 288'(16));

    do_reset();
    stream(1, 0, 71);
    tick();
    chk("b2b_count", 288'(n1), 288'(32));
    chk("b2b_lasts", 288'(l1), 288'(2));

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule

// File: doc/rf_window_streamer.md
# rf_window_streamer

Streaming successor to the combinational receptive-field selector. Accepts an image one pixel (all channels) per cycle, keeps a circular line buffer of the last `Size` rows, and emits one complete `Depth×Size×Size` receptive field per output position in raster order. Supports a configurable `STRIDE` and valid/ready backpressure. It sits between the feature-map source and the conv/FC MAC arrays, replacing whole-image buses with a `W`-deep row store.

## Interface
- `DATA_WIDTH`, 16: bits per element (FP16).
- `Depth`, 1: input channels.
- `Size`, 5: square filter size; 2 ≤ `Size` ≤ `H`, `Size` ≤ `W`.
- `H`, 32: image height.
- `W`, 32: image width.
- `STRIDE`, 1: window step in both directions; ≥ 1.
- Derived values:
  - `OH = (H-Size)/STRIDE+1` and `OW = (W-Size)/STRIDE+1`, with floor division; trailing rows and columns are consumed but never windowed.
  - `WIN_W = Depth*Size*Size*DATA_WIDTH`.

Ports:
- `clk`, in, 1: single clock. All logic runs on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `in_pixel`, in, `Depth*DATA_WIDTH`: one pixel. Channel k is at `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `in_valid`, in, 1: `in_pixel` is valid.
- `in_ready`, out, 1: the block can accept a pixel.
- `out_window`, out, `WIN_W`: receptive field. Element (k,i,j) is at `[((k*Size+i)*Size+j)*DATA_WIDTH +: DATA_WIDTH]`.
  - k = channel.
  - i = window row, 0 = top.
  - j = window column, 0 = left.
- `out_valid`, out, 1: `out_window` is valid.
- `out_ready`, in, 1: the consumer accepts the window.
- `out_last`, out, 1: qualifies the final window (OH-1, OW-1) of a frame.

## Operation
- Pixels arrive in raster order (row-major, column fastest). A transfer is `in_valid && in_ready`.
- Position counters `row` (0..H-1) and `col` (0..W-1) track the accepted pixel.
  - `col` wraps to 0 at W-1 and `row` increments.
  - At (H-1, W-1) both return to 0, and the next pixel starts a new frame with no gap.
- The line buffer holds `Size` rows × `W` columns × `Depth` channels. Pixel (r,c) is written into slot `r mod Size`, column c.
- A window is produced when the accepted pixel (r,c) satisfies all of:
  - r ≥ Size-1 and c ≥ Size-1;
  - (r-Size+1) mod STRIDE = 0 and (c-Size+1) mod STRIDE = 0;
  - (r-Size+1)/STRIDE < OH and (c-Size+1)/STRIDE < OW.
- Window content is image rows r-Size+1..r and columns c-Size+1..c.
  - Rows are mapped to slots in rotation, so window row i=0 is the oldest row.
  - The incoming pixel itself supplies element (k, Size-1, Size-1).
- The output register is one-deep.
  - `in_ready = !out_valid || out_ready`.
  - A window-producing transfer loads `out_window`, `out_valid`=1 and `out_last`.
  - Otherwise, `out_ready && out_valid` clears `out_valid`.
- States:
  - FILL: `row` < Size-1; no windows are produced.
  - STREAM: windows are produced per the rule above.
  - Transitions: FILL → STREAM on accepting (Size-2, W-1). STREAM → FILL on accepting (H-1, W-1).
- Reset:
  - Clears `row`, `col`, state to FILL, `out_valid`=0, `out_last`=0, `out_window`=0.
  - `in_ready`=1 in the cycle after reset deasserts.
  - Line buffer contents are not cleared; they are overwritten before use.
  - Reset mid-frame discards the partial frame. The next accepted pixel is (0,0).

## Timing
- Latency: the window appears on `out_valid` in the cycle after its bottom-right pixel is accepted.
- Throughput: 1 pixel per cycle when `out_ready` is held high.
- Simultaneous events:
  - An `out_ready` handshake and a new window-producing transfer in the same cycle cause the new window to replace the old; `out_valid` stays 1.
- Backpressure:
  - With `out_valid`=1 and `out_ready`=0, `in_ready`=0. Counters, the buffer and the output hold.
- `out_window` and `out_last` are stable while `out_valid && !out_ready`.
- Counter widths are `$clog2(H)` and `$clog2(W)`. Slot index and stride phase counters are used instead of multiply/modulo on row/col.

## Structure
- Package `rf_pkg`:
  - holds the `clog2`-based width constants and a `win_idx(k,i,j)` function for bit offsets;
  - is shared with the verification model.
- Sub-module `rf_line_buffer`:
  - a `Size`×`W` array of `Depth*DATA_WIDTH` registers;
  - one write port (slot, col);
  - a parallel read of `Size` columns c-Size+1..c from all slots.
- The top level holds the counters, FILL/STREAM FSM, stride phase counters, slot-rotation mapping and the output register.

## Test plan
- H=W=6, Size=3, STRIDE=1, Depth=1, pixel value = r*6+c, `out_ready`=1:
  - first `out_valid` one cycle after pixel 14, with window {0,1,2,6,7,8,12,13,14};
  - 16 windows in total;
  - `out_last` only on the window ending at pixel 35.
- Same image with STRIDE=2:
  - 4 windows, ending at pixels 14, 16, 26, 28;
  - the window ending at 28 = {14,15,16,20,21,22,26,27,28} with `out_last`=1.
- Depth=2, channel1 = 100+channel0, H=W=6, Size=3:
  - first window has elements 0..8 = {0,1,2,6,7,8,12,13,14};
  - elements 9..17 = {100,101,102,106,107,108,112,113,114}.
- Backpressure: hold `out_ready`=0 for 5 cycles after the first window.
  - `in_ready`=0 throughout and the window stays stable.
  - Releasing `out_ready` resumes the stream with no lost or duplicated windows; the total stays 16.
- Reset pulse after pixel 20:
  - `out_valid`=0 next cycle;
  - the restarted frame produces the first window after its 15th pixel, identical to scenario 1.
- Two back-to-back frames with no gap: 32 windows, `out_last` exactly twice.
